// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling window generator.
//   DATA_W_DEF     default pixel width
//   IMG_W_DEF/H    default frame geometry
//   pixel_t        default-width pixel type
//   cnt_w()        counter width helper (never narrower than 1 bit)
//   COL_W_DEF/ROW_W_DEF  counter widths for the default geometry
package pool_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int IMG_W_DEF  = 8;
  localparam int IMG_H_DEF  = 8;

  typedef logic [DATA_W_DEF-1:0] pixel_t;

  // Bits needed to count 0..n-1. A 1-entry range still needs one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W_DEF = cnt_w(IMG_W_DEF);
  localparam int ROW_W_DEF = cnt_w(IMG_H_DEF);

endpackage

// File: rtl/pool_line_buf.sv
// One-row pixel store for the window generator.
//   clk      write clock
//   we       write enable (even rows only)
//   waddr    write column
//   wdata    pixel to store
//   raddr_a  left-column read address
//   raddr_b  right-column read address
//   rdata_a  combinational read of raddr_a
//   rdata_b  combinational read of raddr_b
// Contents are not reset; every entry is rewritten by an even row before
// any odd row reads it.
module pool_line_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/pool_window_gen.sv
// Raster-stream to 2x2 stride-2 window generator feeding the max-pool stage.
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    in_data accepted on this edge
//   in_data     pixel, raster order
//   v1..v4      window TL, TR, BL, BR (held until the next window)
//   win_valid   one-cycle pulse, v1..v4 carry a new window
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
//   win_count   (POOL_WIN_CNT_EN only) windows emitted in the current frame
// Optional build macro: POOL_WIN_CNT_EN adds the win_count port and counter.
module pool_window_gen
  import pool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] v1,
  output logic [DATA_W-1:0] v2,
  output logic [DATA_W-1:0] v3,
  output logic [DATA_W-1:0] v4,
  output logic              win_valid,
  output logic              frame_done
`ifdef POOL_WIN_CNT_EN
  ,
  output logic [15:0]       win_count
`endif
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] left_px;
  logic [DATA_W-1:0] lb_rd_l;
  logic [DATA_W-1:0] lb_rd_r;
  logic [CW-1:0]     lb_raddr_l;
  logic              lb_we;
  logic              odd_row;
  logic              odd_col;
  logic              col_end;
  logic              row_end;

  assign odd_row = row[0];
  assign odd_col = col[0];
  assign col_end = (col == COL_LAST);
  assign row_end = (row == ROW_LAST);

  // Even rows fill the buffer; odd rows only read it, so no hazard.
  assign lb_we = in_valid && !odd_row && !rst;

  // Reads are only consumed at odd columns, where clearing bit 0 equals
  // col-1 and also keeps the address in range at col 0.
  assign lb_raddr_l = col & ~CW'(1);

  pool_line_buf #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_W),
    .AW    (CW)
  ) u_line_buf (
    .clk     (clk),
    .we      (lb_we),
    .waddr   (col),
    .wdata   (in_data),
    .raddr_a (lb_raddr_l),
    .raddr_b (col),
    .rdata_a (lb_rd_l),
    .rdata_b (lb_rd_r)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      left_px    <= '0;
      v1         <= '0;
      v2         <= '0;
      v3         <= '0;
      v4         <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (odd_row) begin
          if (odd_col) begin
            v1        <= lb_rd_l;
            v2        <= lb_rd_r;
            v3        <= left_px;
            v4        <= in_data;
            win_valid <= 1'b1;
          end else begin
            left_px <= in_data;
          end
        end
        // Raster position; the frame rolls over with no idle cycle.
        if (col_end) begin
          col <= '0;
          if (row_end) begin
            row        <= '0;
            frame_done <= 1'b1;
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

`ifdef POOL_WIN_CNT_EN
  // Counts registered pulses, so the clear from frame_done lands one cycle
  // after the final window and wins over that window's increment.
  always_ff @(posedge clk) begin
    if (rst || frame_done) win_count <= '0;
    else if (win_valid)    win_count <= win_count + 16'd1;
  end
`endif

endmodule
